// File: rtl/cmos_pixel_pack.sv
// Packs the byte stream of a parallel CMOS sensor into whole pixels and crops
// them to a fixed window, after skipping a number of start-up frames.
module cmos_pixel_pack #(
  parameter int unsigned BPP         = 2,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SKIP_FRAMES = 2,
  parameter int unsigned X0          = 0,
  parameter int unsigned Y0          = 0,
  parameter int unsigned W           = 480,
  parameter int unsigned H           = 272,
  parameter bit          VS_POL      = 1'b1,
  parameter bit          SWAP_RB     = 1'b0
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 vsync_i,
  input  logic                 de_i,
  input  logic [7:0]           pdata_i,
  output logic [8*BPP-1:0]     pix_o,
  output logic                 pix_de_o,
  output logic                 sof_o,
  output logic                 eol_o,
  output logic [CNT_W-1:0]     x_o,
  output logic [CNT_W-1:0]     y_o,
  output logic                 line_err_o
);

  localparam int unsigned PW = 8 * BPP;
  localparam int unsigned XW = CNT_W + 1;
  localparam logic [XW-1:0] X_LO   = XW'(X0);
  localparam logic [XW-1:0] X_HI   = XW'(X0 + W);
  localparam logic [XW-1:0] X_LAST = XW'(X0 + W - 1);
  localparam logic [XW-1:0] Y_LO   = XW'(Y0);
  localparam logic [XW-1:0] Y_HI   = XW'(Y0 + H);
  localparam logic [1:0]    PH_LAST = 2'(BPP - 1);
  localparam logic [3:0]    SKIP_N  = 4'(SKIP_FRAMES);

  typedef enum logic [1:0] {WAIT_VS, SKIP, RUN} state_t;

  state_t            state;
  logic              vs_r, vs_q, de_r, de_q;
  logic [7:0]        d_r;
  logic [1:0]        ph;
  logic [CNT_W-1:0]  x, y;
  logic [3:0]        skip_cnt;
  logic              line_pix;
  logic              abort;
  logic [PW-1:0]     acc;

  logic              vs_edge, line_start, line_end, byte_ok, done, in_win;
  logic [1:0]        ph_eff;
  logic [CNT_W-1:0]  x_eff, x_inc;
  logic [PW-1:0]     pix_raw, pix_sel;

  assign vs_edge    = (vs_r == VS_POL) && (vs_q != VS_POL);
  assign line_start = de_r && !de_q;
  assign line_end   = !de_r && de_q;
  assign ph_eff     = line_start ? 2'd0 : ph;
  assign x_eff      = line_start ? '0 : x;
  assign x_inc      = (x_eff == '1) ? x_eff : x_eff + CNT_W'(1);
  // A vsync edge wins over any byte; an aborted line ignores bytes until its end.
  assign byte_ok    = de_r && !vs_edge && !(abort && !line_start);
  assign done       = byte_ok && (ph_eff == PH_LAST);
  assign pix_raw    = PW'({acc, d_r});
  assign in_win     = ({1'b0, x_eff} >= X_LO) && ({1'b0, x_eff} < X_HI) &&
                      ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

  generate
    if (SWAP_RB && BPP == 2) begin : g_swap
      assign pix_sel = {pix_raw[4:0], pix_raw[10:5], pix_raw[15:11]};
    end else begin : g_noswap
      assign pix_sel = pix_raw;
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= WAIT_VS;
      vs_r       <= 1'b0;
      vs_q       <= 1'b0;
      de_r       <= 1'b0;
      de_q       <= 1'b0;
      d_r        <= '0;
      ph         <= '0;
      x          <= '0;
      y          <= '0;
      skip_cnt   <= '0;
      line_pix   <= 1'b0;
      abort      <= 1'b0;
      acc        <= '0;
      pix_o      <= '0;
      pix_de_o   <= 1'b0;
      sof_o      <= 1'b0;
      eol_o      <= 1'b0;
      x_o        <= '0;
      y_o        <= '0;
      line_err_o <= 1'b0;
    end else begin
      vs_r       <= vsync_i;
      vs_q       <= vs_r;
      de_r       <= de_i;
      de_q       <= de_r;
      d_r        <= pdata_i;
      pix_de_o   <= 1'b0;
      sof_o      <= 1'b0;
      eol_o      <= 1'b0;
      line_err_o <= 1'b0;

      if (vs_edge) begin
        ph       <= '0;
        x        <= '0;
        y        <= '0;
        line_pix <= 1'b0;
        abort    <= de_r;
        // Frame-skip sequencing advances only on vsync edges.
        case (state)
          WAIT_VS: begin
            skip_cnt <= '0;
            state    <= (SKIP_N == 4'd0) ? RUN : SKIP;
          end
          SKIP: begin
            skip_cnt <= skip_cnt + 4'd1;
            if (skip_cnt + 4'd1 == SKIP_N) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end else if (line_end) begin
        ph    <= '0;
        abort <= 1'b0;
        if (ph != 2'd0 && !abort && state == RUN) line_err_o <= 1'b1;
        if (line_pix && !abort && y != '1) y <= y + CNT_W'(1);
      end else if (byte_ok) begin
        acc   <= pix_raw;
        abort <= 1'b0;
        if (done) begin
          ph       <= '0;
          x        <= x_inc;
          line_pix <= 1'b1;
          pix_o    <= pix_sel;
          x_o      <= x_eff;
          y_o      <= y;
          if (state == RUN && in_win) begin
            pix_de_o <= 1'b1;
            sof_o    <= ({1'b0, x_eff} == X_LO) && ({1'b0, y} == Y_LO);
            eol_o    <= ({1'b0, x_eff} == X_LAST);
          end
        end else begin
          ph       <= ph_eff + 2'd1;
          x        <= x_eff;
          if (line_start) line_pix <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Scoreboard bench for cmos_pixel_pack: three configurations (RGB565 basic,
// RGB565 with frame skip and R/B swap, RGB888 cropped) driven with directed lines.
module tb_cmos_pixel_pack;

  typedef struct packed {
    logic [23:0] pix;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs [3];
  logic        de [3];
  logic [7:0]  pd [3];

  logic [15:0] pix0, pix1;
  logic [23:0] pix2;
  logic [23:0] pix_a [3];
  logic        pde [3], sof [3], eol [3], lerr [3];
  logic [11:0] xo [3], yo [3];

  exp_t        q [3][$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          lerr_cnt [3] = '{0, 0, 0};
  int          lerr_exp [3] = '{1, 0, 1};
  logic        chk_reset = 1'b0;
  logic        chk_end = 1'b0;
  logic [7:0]  rgb [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hF8, 8'h1F};

  always #5 clk = ~clk;

  assign pix_a[0] = {8'h00, pix0};
  assign pix_a[1] = {8'h00, pix1};
  assign pix_a[2] = pix2;

  cmos_pixel_pack #(.BPP(2), .SKIP_FRAMES(0), .W(4), .H(2)) dut_a (
    .pclk(clk), .rst(rst), .vsync_i(vs[0]), .de_i(de[0]), .pdata_i(pd[0]),
    .pix_o(pix0), .pix_de_o(pde[0]), .sof_o(sof[0]), .eol_o(eol[0]),
    .x_o(xo[0]), .y_o(yo[0]), .line_err_o(lerr[0]));

  cmos_pixel_pack #(.BPP(2), .SKIP_FRAMES(2), .W(4), .H(2), .SWAP_RB(1'b1)) dut_b (
    .pclk(clk), .rst(rst), .vsync_i(vs[1]), .de_i(de[1]), .pdata_i(pd[1]),
    .pix_o(pix1), .pix_de_o(pde[1]), .sof_o(sof[1]), .eol_o(eol[1]),
    .x_o(xo[1]), .y_o(yo[1]), .line_err_o(lerr[1]));

  cmos_pixel_pack #(.BPP(3), .SKIP_FRAMES(0), .X0(1), .W(2), .H(4)) dut_c (
    .pclk(clk), .rst(rst), .vsync_i(vs[2]), .de_i(de[2]), .pdata_i(pd[2]),
    .pix_o(pix2), .pix_de_o(pde[2]), .sof_o(sof[2]), .eol_o(eol[2]),
    .x_o(xo[2]), .y_o(yo[2]), .line_err_o(lerr[2]));

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (chk_reset) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({pix_a[i], pde[i], sof[i], eol[i], xo[i], yo[i], lerr[i]} !== '0) begin
          errors++;
          $display("FAIL reset_state dut%0d got pix=%h de=%b sof=%b eol=%b x=%0d y=%0d err=%b, need all zero",
                   i, pix_a[i], pde[i], sof[i], eol[i], xo[i], yo[i], lerr[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (lerr[i] === 1'b1) lerr_cnt[i]++;
      if ((sof[i] || eol[i]) && !pde[i]) begin
        checks++;
        errors++;
        $display("FAIL stray_marker dut%0d sof=%b eol=%b without pix_de", i, sof[i], eol[i]);
      end
      if (pde[i] === 1'b1) begin
        checks++;
        if (q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel dut%0d got pix=%h x=%0d y=%0d, none expected",
                   i, pix_a[i], xo[i], yo[i]);
        end else begin
          e = q[i].pop_front();
          if ({pix_a[i], xo[i], yo[i], sof[i], eol[i]} !== e) begin
            errors++;
            $display("FAIL pixel dut%0d got pix=%h x=%0d y=%0d sof=%b eol=%b, need pix=%h x=%0d y=%0d sof=%b eol=%b",
                     i, pix_a[i], xo[i], yo[i], sof[i], eol[i], e.pix, e.x, e.y, e.sof, e.eol);
          end
        end
      end
    end
    if (chk_end) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q[i].size() != 0) begin
          errors++;
          $display("FAIL missing_pixels dut%0d got %0d still pending, need 0", i, q[i].size());
        end
        checks++;
        if (lerr_cnt[i] != lerr_exp[i]) begin
          errors++;
          $display("FAIL line_err_count dut%0d got %0d, need %0d", i, lerr_cnt[i], lerr_exp[i]);
        end
      end
    end
  end

  task automatic drive(input int i, input logic v, input logic d, input logic [7:0] b);
    @(negedge clk);
    vs[i] = v;
    de[i] = d;
    pd[i] = b;
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) drive(i, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync(input int i);
    drive(i, 1'b1, 1'b0, 8'h00);
    drive(i, 1'b1, 1'b0, 8'h00);
    idle(i, 4);
  endtask

  task automatic line(input int i, input logic [7:0] b0, input int n);
    for (int k = 0; k < n; k++) drive(i, 1'b0, 1'b1, b0 + 8'(k));
    idle(i, 4);
  endtask

  task automatic line_rgb(input int i);
    for (int k = 0; k < 8; k++) drive(i, 1'b0, 1'b1, rgb[k]);
    idle(i, 4);
  endtask

  task automatic expect_pix(input int i, input logic [23:0] p, input int x, input int y,
                            input logic s, input logic l);
    q[i].push_back('{pix: p, x: 12'(x), y: 12'(y), sof: s, eol: l});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vs[i] = 1'b0;
      de[i] = 1'b0;
      pd[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    chk_reset = 1'b1;
    @(posedge clk);
    chk_reset = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Basic RGB565 packing, two lines inside a 4x2 window.
    vsync(0);
    for (int yy = 0; yy < 2; yy++) begin
      expect_pix(0, 24'h0102, 0, yy, yy == 0, 1'b0);
      expect_pix(0, 24'h0304, 1, yy, 1'b0, 1'b0);
      expect_pix(0, 24'h0506, 2, yy, 1'b0, 1'b0);
      expect_pix(0, 24'h0708, 3, yy, 1'b0, 1'b1);
      line(0, 8'h01, 8);
    end
    // Third line falls below the window: no strobes.
    line(0, 8'h01, 8);

    // Odd byte count: three pixels and one line error, next line clean.
    vsync(0);
    expect_pix(0, 24'h0102, 0, 0, 1'b1, 1'b0);
    expect_pix(0, 24'h0304, 1, 0, 1'b0, 1'b0);
    expect_pix(0, 24'h0506, 2, 0, 1'b0, 1'b0);
    line(0, 8'h01, 7);
    expect_pix(0, 24'h1112, 0, 1, 1'b0, 1'b0);
    expect_pix(0, 24'h1314, 1, 1, 1'b0, 1'b0);
    expect_pix(0, 24'h1516, 2, 1, 1'b0, 1'b0);
    expect_pix(0, 24'h1718, 3, 1, 1'b0, 1'b1);
    line(0, 8'h11, 8);
    line(0, 8'h01, 8);

    // Vsync edge mid-line: byte coinciding with the edge is dropped, rest of line ignored.
    drive(0, 1'b0, 1'b1, 8'h01);
    drive(0, 1'b1, 1'b1, 8'h02);
    drive(0, 1'b1, 1'b1, 8'h03);
    for (int k = 4; k <= 8; k++) drive(0, 1'b0, 1'b1, 8'(k));
    idle(0, 4);
    expect_pix(0, 24'h2122, 0, 0, 1'b1, 1'b0);
    expect_pix(0, 24'h2324, 1, 0, 1'b0, 1'b0);
    expect_pix(0, 24'h2526, 2, 0, 1'b0, 1'b0);
    expect_pix(0, 24'h2728, 3, 0, 1'b0, 1'b1);
    line(0, 8'h21, 8);

    // Reset in the middle of a line; output only after a new vsync.
    expect_pix(0, 24'h3132, 0, 1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1, 8'h31);
    drive(0, 1'b0, 1'b1, 8'h32);
    drive(0, 1'b0, 1'b1, 8'h33);
    drive(0, 1'b0, 1'b1, 8'h34);
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, 8'h35);
    rst = 1'b0;
    for (int k = 6; k <= 8; k++) drive(0, 1'b0, 1'b1, 8'h30 + 8'(k));
    idle(0, 4);
    line(0, 8'h51, 8);
    vsync(0);
    expect_pix(0, 24'h4142, 0, 0, 1'b1, 1'b0);
    expect_pix(0, 24'h4344, 1, 0, 1'b0, 1'b0);
    expect_pix(0, 24'h4546, 2, 0, 1'b0, 1'b0);
    expect_pix(0, 24'h4748, 3, 0, 1'b0, 1'b1);
    line(0, 8'h41, 8);

    // Frame skip of two with R/B swap: only the third frame is emitted.
    for (int f = 0; f < 3; f++) begin
      vsync(1);
      for (int yy = 0; yy < 2; yy++) begin
        if (f == 2) begin
          expect_pix(1, 24'h001F, 0, yy, yy == 0, 1'b0);
          expect_pix(1, 24'h07E0, 1, yy, 1'b0, 1'b0);
          expect_pix(1, 24'hF800, 2, yy, 1'b0, 1'b0);
          expect_pix(1, 24'hF81F, 3, yy, 1'b0, 1'b1);
        end
        line_rgb(1);
      end
    end

    // RGB888 with a 2-pixel window starting at x=1.
    vsync(2);
    expect_pix(2, 24'h131415, 1, 0, 1'b1, 1'b0);
    expect_pix(2, 24'h161718, 2, 0, 1'b0, 1'b1);
    line(2, 8'h10, 12);
    expect_pix(2, 24'h131415, 1, 1, 1'b0, 1'b0);
    expect_pix(2, 24'h161718, 2, 1, 1'b0, 1'b1);
    line(2, 8'h10, 13);

    idle(2, 8);
    @(posedge clk);
    chk_end = 1'b1;
    @(posedge clk);
    chk_end = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
